// File: rtl/dds_modulator_pkg.sv
// dds_modulator_pkg
// Shared constants and types for the DDS modulator register bank.
//   REG_CTRL           word index of the control register
//   CTRL_*_BIT         bit positions inside CTRL
//   CTRL_WR_MASK       CTRL bits that a write may store (COMMIT and PEND are not storable)
//   axi_resp_t         AXI response encodings used by the bank
//   merge_bytes()      byte-lane merge of a write into an existing word
// Optional feature macro used by the bank: DDS_REGBANK_FRAMECNT_EN
package dds_modulator_pkg;

  localparam int REG_CTRL        = 0;
  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_DBG_BIT    = 1;
  localparam int CTRL_COMMIT_BIT = 2;
  localparam int CTRL_PEND_BIT   = 31;

  // COMMIT is a write-1 strobe and PEND is a live status bit, so neither is
  // ever kept in the stored CTRL word.
  localparam logic [31:0] CTRL_WR_MASK =
    ~((32'd1 << CTRL_COMMIT_BIT) | (32'd1 << CTRL_PEND_BIT));

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_t;

  // Replace only the bytes whose strobe is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] result;
    result = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        result[8*b +: 8] = new_word[8*b +: 8];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/axi_lite_wr_hold.sv
// axi_lite_wr_hold
// AXI4-lite write channel front end: captures AW and W independently into
// one-deep holds, presents a single-cycle write strobe once both are held,
// and returns the B response the cycle after.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   awaddr/awvalid/awready   write address channel
//   wdata/wstrb/wvalid/wready write data channel
//   bresp/bvalid/bready      write response channel
//   wr_en                    write executes this cycle (both holds full)
//   wr_addr/wr_data/wr_strb  held address, data and strobes
//   wr_resp                  response for the write, decided by the bank
module axi_lite_wr_hold #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_strb,
  input  logic [1:0]        wr_resp
);
  import dds_modulator_pkg::*;

  logic aw_held;
  logic w_held;
  logic accept_en;

  // Readies stay low while in reset; accept_en lifts them the cycle after.
  assign awready = accept_en & ~aw_held & ~bvalid;
  assign wready  = accept_en & ~w_held & ~bvalid;
  assign wr_en   = aw_held & w_held;

  // Hold capture, write completion and response handshake. Once both holds
  // are full the readies are already low, so a capture never coincides
  // with the write that empties the holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      accept_en <= 1'b0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_strb   <= '0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
    end else begin
      accept_en <= 1'b1;
      if (awvalid && awready) begin
        aw_held <= 1'b1;
        wr_addr <= awaddr;
      end
      if (wvalid && wready) begin
        w_held  <= 1'b1;
        wr_data <= wdata;
        wr_strb <= wstrb;
      end
      if (wr_en) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= wr_resp;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi_lite_dds_shadow_regbank.sv
// axi_lite_dds_shadow_regbank
// AXI4-lite register bank for the DDS modulator with shadow/active double
// buffering. CTRL (reg 0) is written straight to the active image; regs
// 1..NUM_REGS-1 are written to the shadow image and copied to active in one
// cycle on commit (at a frame end, or immediately when EN is low).
// Ports:
//   S_AXI_CLK, S_AXI_RESET   clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*          AXI4-lite write channels
//   S_AXI_AR*/R*             AXI4-lite read channels
//   frame_end_i              one-cycle frame boundary pulse from the modulator
//   config_o                 active register image, reg k at [32k+31:32k]
//   pending_o                shadow image awaits commit
// Optional feature: define DDS_REGBANK_FRAMECNT_EN to add a read-only frame
// counter at word index NUM_REGS.
module axi_lite_dds_shadow_regbank #(
  parameter int                         NUM_REGS = 8,
  parameter int                         ADDR_W   = 8,
  parameter logic [NUM_REGS-1:0][31:0]  RST_VAL  = '0
) (
  input  logic                    S_AXI_CLK,
  input  logic                    S_AXI_RESET,
  input  logic [ADDR_W-1:0]       S_AXI_AWADDR,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [31:0]             S_AXI_WDATA,
  input  logic [3:0]              S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [ADDR_W-1:0]       S_AXI_ARADDR,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [31:0]             S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,
  input  logic                    frame_end_i,
  output logic [NUM_REGS*32-1:0]  config_o,
  output logic                    pending_o
);
  import dds_modulator_pkg::*;

  logic [31:0]       shadow_regs [NUM_REGS];
  logic [31:0]       active_regs [NUM_REGS];
  logic              pending;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic [1:0]        wr_resp;
  logic [31:0]       wr_idx;
  logic              wr_in_range;
  logic              wr_is_ctrl;
  logic [31:0]       ctrl_wr_word;
  logic              commit_req;
  logic              commit_fire;

  logic [31:0]       rd_idx;
  logic [31:0]       rd_word;
  axi_resp_t         rd_resp;
  logic              ar_fire;
  logic              ar_accept_en;
  logic              unused_addr_bits;

  axi_lite_wr_hold #(
    .ADDR_W (ADDR_W)
  ) u_wr_hold (
    .clk     (S_AXI_CLK),
    .reset   (S_AXI_RESET),
    .awaddr  (S_AXI_AWADDR),
    .awvalid (S_AXI_AWVALID),
    .awready (S_AXI_AWREADY),
    .wdata   (S_AXI_WDATA),
    .wstrb   (S_AXI_WSTRB),
    .wvalid  (S_AXI_WVALID),
    .wready  (S_AXI_WREADY),
    .bresp   (S_AXI_BRESP),
    .bvalid  (S_AXI_BVALID),
    .bready  (S_AXI_BREADY),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .wr_resp (wr_resp)
  );

  // The byte offset within a word has no meaning for this bank.
  assign unused_addr_bits = ^{wr_addr[1:0], S_AXI_ARADDR[1:0]};

  assign wr_idx      = 32'(wr_addr[ADDR_W-1:2]);
  assign rd_idx      = 32'(S_AXI_ARADDR[ADDR_W-1:2]);
  assign wr_in_range = wr_idx < $unsigned(NUM_REGS);
  assign wr_is_ctrl  = wr_idx == $unsigned(REG_CTRL);
  assign wr_resp     = wr_in_range ? RESP_OKAY : RESP_SLVERR;

  // Non-storable CTRL bits keep their previous value regardless of the data.
  assign ctrl_wr_word = merge_bytes(active_regs[REG_CTRL],
                                    (wr_data & CTRL_WR_MASK) |
                                    (active_regs[REG_CTRL] & ~CTRL_WR_MASK),
                                    wr_strb);

  assign commit_req  = wr_en & wr_is_ctrl & wr_strb[0] & wr_data[CTRL_COMMIT_BIT];
  assign commit_fire = pending &
                       (frame_end_i | ~active_regs[REG_CTRL][CTRL_EN_BIT]);

  // Register images and commit. Non-blocking updates mean a shadow write in
  // the commit cycle stays in shadow while active takes the old value.
  // A COMMIT written while already pending changes nothing.
  always_ff @(posedge S_AXI_CLK) begin
    if (S_AXI_RESET) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        shadow_regs[k] <= RST_VAL[k];
        active_regs[k] <= RST_VAL[k];
      end
      pending <= 1'b0;
    end else begin
      if (commit_fire) begin
        for (int k = 1; k < NUM_REGS; k++) begin
          active_regs[k] <= shadow_regs[k];
        end
        pending <= 1'b0;
      end else if (commit_req) begin
        pending <= 1'b1;
      end
      if (wr_en && wr_in_range) begin
        if (wr_is_ctrl) begin
          active_regs[REG_CTRL] <= ctrl_wr_word;
        end else begin
          for (int k = 1; k < NUM_REGS; k++) begin
            if (wr_idx == 32'(k)) begin
              shadow_regs[k] <= merge_bytes(shadow_regs[k], wr_data, wr_strb);
            end
          end
        end
      end
    end
  end

`ifdef DDS_REGBANK_FRAMECNT_EN
  logic [31:0] frame_cnt;
  logic        en_rise;

  // EN can only rise through a CTRL write with lane 0 enabled.
  assign en_rise = wr_en & wr_is_ctrl & wr_strb[0] & wr_data[CTRL_EN_BIT] &
                   ~active_regs[REG_CTRL][CTRL_EN_BIT];

  // Frames seen while enabled; the counter wraps naturally at 2^32.
  always_ff @(posedge S_AXI_CLK) begin
    if (S_AXI_RESET) begin
      frame_cnt <= '0;
    end else if (en_rise) begin
      frame_cnt <= '0;
    end else if (frame_end_i && active_regs[REG_CTRL][CTRL_EN_BIT]) begin
      frame_cnt <= frame_cnt + 32'd1;
    end
  end
`endif

  // Read data selection: CTRL reports the live pending flag in its top bit,
  // configuration registers report what software wrote (the shadow copy).
  always_comb begin
    rd_word = '0;
    rd_resp = RESP_SLVERR;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_idx == 32'(k)) begin
        rd_resp = RESP_OKAY;
        if (k == REG_CTRL) begin
          rd_word                = active_regs[REG_CTRL];
          rd_word[CTRL_PEND_BIT] = pending;
        end else begin
          rd_word = shadow_regs[k];
        end
      end
    end
`ifdef DDS_REGBANK_FRAMECNT_EN
    if (rd_idx == $unsigned(NUM_REGS)) begin
      rd_resp = RESP_OKAY;
      rd_word = frame_cnt;
    end
`endif
  end

  assign S_AXI_ARREADY = ar_accept_en & ~S_AXI_RVALID;
  assign ar_fire       = S_AXI_ARVALID & S_AXI_ARREADY;

  // Registered read response, held until the master takes it.
  always_ff @(posedge S_AXI_CLK) begin
    if (S_AXI_RESET) begin
      ar_accept_en <= 1'b0;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
    end else begin
      ar_accept_en <= 1'b1;
      if (ar_fire) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_word;
        S_AXI_RRESP  <= rd_resp;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_config
    assign config_o[32*g +: 32] = active_regs[g];
  end

  assign pending_o = pending;

endmodule

// File: tb/tb_axi_lite_dds_shadow_regbank.sv
// tb_axi_lite_dds_shadow_regbank
// Directed bench for the shadow register bank. Stimulus tasks push the
// expected B/R responses into queues; a monitor pops and compares them
// whenever BVALID or RVALID is presented. Direct checks on config_o and
// pending_o are made from the stimulus process.
module tb_axi_lite_dds_shadow_regbank;

  localparam int          NUM_REGS = 8;
  localparam int          ADDR_W   = 8;
  localparam logic [1:0]  OKAY     = 2'b00;
  localparam logic [1:0]  SLVERR   = 2'b10;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    string       name;
  } exp_t;

  logic                   clk;
  logic                   reset;
  logic [ADDR_W-1:0]      awaddr;
  logic                   awvalid;
  logic                   awready;
  logic [31:0]            wdata;
  logic [3:0]             wstrb;
  logic                   wvalid;
  logic                   wready;
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready;
  logic [ADDR_W-1:0]      araddr;
  logic                   arvalid;
  logic                   arready;
  logic [31:0]            rdata;
  logic [1:0]             rresp;
  logic                   rvalid;
  logic                   rready;
  logic                   frame_end;
  logic [NUM_REGS*32-1:0] config_word;
  logic                   pending;

  exp_t bq[$];
  exp_t rq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_b_cyc = 0;
  int   w_acc_cyc  = 0;

  axi_lite_dds_shadow_regbank #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) dut (
    .S_AXI_CLK     (clk),
    .S_AXI_RESET   (reset),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .frame_end_i   (frame_end),
    .config_o      (config_word),
    .pending_o     (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] cfg(input int k);
    return config_word[32*k +: 32];
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Response monitor: compares every presented B and R beat against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (bvalid && bready) begin
      last_b_cyc = cyc;
      n_checks++;
      if (bq.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_b: got bresp %0d with nothing expected", bresp);
      end else begin
        e = bq.pop_front();
        if (bresp !== e.resp) begin
          n_fail++;
          $display("[TB] FAIL %s bresp: got %0d expected %0d", e.name, bresp, e.resp);
        end
      end
    end
    if (rvalid && rready) begin
      n_checks++;
      if (rq.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_r: got rdata 0x%08h with nothing expected", rdata);
      end else begin
        e = rq.pop_front();
        if (rresp !== e.resp || rdata !== e.data) begin
          n_fail++;
          $display("[TB] FAIL %s read: got resp %0d data 0x%08h expected resp %0d data 0x%08h",
                   e.name, rresp, rdata, e.resp, e.data);
        end
      end
    end
  end

  task automatic wait_drain();
    int k = 0;
    while ((bq.size() != 0 || rq.size() != 0) && k < 40) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (bq.size() != 0 || rq.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain_timeout: got %0d B and %0d R responses missing expected 0",
               bq.size(), rq.size());
      bq.delete();
      rq.delete();
    end
  endtask

  // AXI write with W issued w_delay cycles after AW is presented.
  task automatic apply_stimulus(input logic [7:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input int w_delay,
                                input logic [1:0] exp_resp, input string name);
    exp_t e;
    bit   aw_done = 0;
    bit   w_done  = 0;
    bit   aw_fire;
    bit   w_fire;
    int   k = 0;
    e.resp = exp_resp;
    e.data = '0;
    e.name = name;
    bq.push_back(e);
    @(posedge clk);
    #1;
    awaddr  = addr;
    awvalid = 1'b1;
    wdata   = data;
    wstrb   = strb;
    wvalid  = (w_delay == 0);
    while (!(aw_done && w_done) && k < 40) begin
      @(negedge clk);
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(posedge clk);
      #1;
      k++;
      if (aw_fire) begin
        awvalid = 1'b0;
        aw_done = 1;
      end
      if (w_fire) begin
        wvalid    = 1'b0;
        w_done    = 1;
        w_acc_cyc = cyc;
      end
      if (!w_done && !wvalid && k >= w_delay) wvalid = 1'b1;
    end
    if (!(aw_done && w_done)) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s handshake_timeout: got aw %0d w %0d expected 1 1", name, aw_done, w_done);
      awvalid = 1'b0;
      wvalid  = 1'b0;
    end
  endtask

  task automatic read_reg(input logic [7:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input string name);
    exp_t e;
    bit   fire = 0;
    int   k = 0;
    e.resp = exp_resp;
    e.data = exp_data;
    e.name = name;
    rq.push_back(e);
    @(posedge clk);
    #1;
    araddr  = addr;
    arvalid = 1'b1;
    while (!fire && k < 40) begin
      @(negedge clk);
      fire = arvalid && arready;
      @(posedge clk);
      #1;
      k++;
    end
    arvalid = 1'b0;
    if (!fire) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s ar_timeout: got no handshake expected one", name);
    end
    wait_drain();
  endtask

  task automatic pulse_frame();
    @(posedge clk);
    #1;
    frame_end = 1'b1;
    @(posedge clk);
    #1;
    frame_end = 1'b0;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    reset     = 1'b1;
    awaddr    = '0;
    awvalid   = 1'b0;
    wdata     = '0;
    wstrb     = '0;
    wvalid    = 1'b0;
    bready    = 1'b1;
    araddr    = '0;
    arvalid   = 1'b0;
    rready    = 1'b1;
    frame_end = 1'b0;

    // Reset: handshake outputs low and images at their reset value.
    repeat (3) @(negedge clk);
    check_output("reset_outputs",
                 {awready, wready, arready, bvalid, rvalid, bresp, rresp, pending, 21'd0},
                 32'd0);
    check_output("reset_rdata", rdata, 32'd0);
    check_output("reset_config_or", |config_word, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: every register reads back its reset value.
    for (int i = 0; i < NUM_REGS; i++) begin
      read_reg(8'(i * 4), 32'd0, OKAY, $sformatf("reset_read_%0d", i));
    end
    check_output("reset_pending", pending, 32'd0);

    // 2: split AW/W write to reg3 lands in shadow only.
    apply_stimulus(8'h0C, 32'h0000_1E84, 4'hF, 3, OKAY, "reg3_write");
    wait_drain();
    check_output("bvalid_latency", last_b_cyc - w_acc_cyc, 32'd1);
    check_output("reg3_active_unchanged", cfg(3), 32'd0);
    read_reg(8'h0C, 32'h0000_1E84, OKAY, "reg3_shadow_read");

    // 3: EN low, COMMIT applies on the cycle after the request.
    apply_stimulus(8'h00, 32'h0000_0004, 4'hF, 0, OKAY, "commit_idle");
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!pending && k < 10);
    check_output("pending_set", pending, 32'd1);
    check_output("reg3_before_commit", cfg(3), 32'd0);
    @(negedge clk);
    check_output("reg3_after_commit", cfg(3), 32'h0000_1E84);
    check_output("pending_clear_idle", pending, 32'd0);
    wait_drain();
    read_reg(8'h00, 32'd0, OKAY, "ctrl_commit_not_stored");

    // 4: EN high, commit waits for the frame boundary.
    apply_stimulus(8'h00, 32'h0000_0001, 4'hF, 0, OKAY, "ctrl_en");
    apply_stimulus(8'h10, 32'h0000_9896, 4'hF, 0, OKAY, "reg4_write");
    apply_stimulus(8'h00, 32'h0000_0005, 4'hF, 0, OKAY, "commit_running");
    wait_drain();
    repeat (5) @(negedge clk);
    check_output("pending_held", pending, 32'd1);
    check_output("reg4_held", cfg(4), 32'd0);
    read_reg(8'h00, 32'h8000_0001, OKAY, "ctrl_pending_bit");
    @(posedge clk);
    #1;
    frame_end = 1'b1;
    @(negedge clk);
    check_output("reg4_before_frame_edge", cfg(4), 32'd0);
    @(posedge clk);
    #1;
    frame_end = 1'b0;
    @(negedge clk);
    check_output("reg4_after_frame", cfg(4), 32'h0000_9896);
    check_output("pending_clear_frame", pending, 32'd0);
    check_output("ctrl_active_en", cfg(0), 32'h0000_0001);

    // 5: byte lanes, zero strobe, out-of-range accesses.
    apply_stimulus(8'h14, 32'hAABB_CCDD, 4'b0010, 0, OKAY, "reg5_lane1");
    apply_stimulus(8'h14, 32'hFFFF_FFFF, 4'b0000, 0, OKAY, "reg5_nostrb");
    wait_drain();
    read_reg(8'h14, 32'h0000_CC00, OKAY, "reg5_shadow_read");
    check_output("reg5_active_unchanged", cfg(5), 32'd0);
    apply_stimulus(8'h40, 32'h1234_5678, 4'hF, 0, SLVERR, "write_oor");
    wait_drain();
    read_reg(8'h40, 32'd0, SLVERR, "read_oor");
    apply_stimulus(8'h1C, 32'h0000_0077, 4'hF, 0, OKAY, "reg7_write");
    wait_drain();
    read_reg(8'h1F, 32'h0000_0077, OKAY, "reg7_low_bits_ignored");

`ifdef DDS_REGBANK_FRAMECNT_EN
    // 6: frame counter clears on EN rise and counts frames while enabled.
    apply_stimulus(8'h00, 32'h0000_0000, 4'hF, 0, OKAY, "ctrl_dis");
    apply_stimulus(8'h00, 32'h0000_0001, 4'hF, 0, OKAY, "ctrl_en_again");
    wait_drain();
    repeat (5) pulse_frame();
    read_reg(8'h20, 32'd5, OKAY, "framecnt_5");
    apply_stimulus(8'h00, 32'h0000_0000, 4'hF, 0, OKAY, "ctrl_dis2");
    wait_drain();
    pulse_frame();
    read_reg(8'h20, 32'd5, OKAY, "framecnt_hold_disabled");
    apply_stimulus(8'h00, 32'h0000_0001, 4'hF, 0, OKAY, "ctrl_en2");
    wait_drain();
    read_reg(8'h20, 32'd0, OKAY, "framecnt_cleared");
    apply_stimulus(8'h20, 32'h0000_00AA, 4'hF, 0, SLVERR, "framecnt_write");
    wait_drain();
`else
    read_reg(8'h20, 32'd0, SLVERR, "read_index_num_regs");
    apply_stimulus(8'h20, 32'h0000_00AA, 4'hF, 0, SLVERR, "write_index_num_regs");
    wait_drain();
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
